mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Memory-side responder for the 16-bit multicycle processor's memory bus.
- Serves the datapath's instruction-fetch and load/store requests from a word-addressed single-port array.
- Uses a valid/ready request channel, a valid/ready response channel and a programmable access latency.
- Replaces the zero-wait instruction and data memories so the controller FSM can be exercised against realistic wait states.

Parameters:
- ADDR_W, 16, request address width (word address).
- DATA_W, 16, data word width.
- DEPTH, 256, number of implemented words; addresses >= DEPTH are out of range.
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load/fetch.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator consumes the response.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  address was out of range.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0, busy=0.
  - req_ready is 1 immediately after reset deasserts.
  - Array contents are not reset (undefined until written).
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, combinational from state only (never from req_valid).
  - Accept on the rising edge where req_valid & req_ready. At acceptance, latch write/addr/wdata and load cnt=LATENCY-1.
  - If LATENCY=1, go directly to RESP. Otherwise go to WAIT.
- WAIT:
  - req_ready=0; cnt decrements each cycle.
  - On the edge where cnt==1, perform the access and enter RESP.
  - Net timing: accept at edge N, rsp_valid rises at edge N+LATENCY.
- Access, performed on the edge entering RESP:
  - In-range write: array[addr]<=wdata, rsp_rdata=0, rsp_err=0.
  - In-range read: rsp_rdata=array[addr], rsp_err=0.
  - Out-of-range (addr>=DEPTH): no array write, rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable until handshake.
  - On rsp_valid & rsp_ready: clear rsp_valid, rsp_rdata and rsp_err; return to IDLE.
  - req_ready=0 throughout RESP, so there are no overlapping transactions.
  - Minimum spacing between accepts = LATENCY+1 cycles with rsp_ready held high.
- Request-side stability: req_* are sampled only at the acceptance edge; changes afterward have no effect.
- Reset mid-transaction:
  - In WAIT: the transaction is dropped, no array write occurs, outputs return to reset values.
  - In RESP: the write has already committed and is retained; the pending response is discarded.
- Simultaneous events:
  - req_valid held during RESP is ignored until IDLE.
  - rsp_ready asserted before rsp_valid has no effect.
- Address width rules:
  - Only the low clog2(DEPTH) bits index the array.
  - The range check uses the full ADDR_W bits. No wrap-around: 0x0100 with DEPTH=256 is an error, not an alias of 0x0000.
- Elaboration check: LATENCY outside 1..15 is a fatal elaboration error.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - MEM_ADDR_W=16 and MEM_DATA_W=16;
  - CNT_W=4 latency counter width.
- The same package is also used by the processor-side initiator.
- One sub-module: mem_array_sp, a single-port synchronous RAM (DEPTH x DATA_W) with we, addr, wdata and registered rdata.
  - The responder's timing accounts for its one-cycle read, so LATENCY is measured end to end.

Test Plan:
1. Reset then idle: rst pulse mid-cycle -> all outputs 0 asynchronously, req_ready=1 after release, busy=0.
2. Write then read, LATENCY=2:
   - Store addr 0x0010 data 0xBEEF accepted at edge N -> rsp_valid at N+2 with rsp_err=0, rsp_rdata=0.
   - Load 0x0010 -> rsp_rdata=0xBEEF at accept+2.
3. Back-pressure: load with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held stable, req_ready=0 throughout; rsp_ready=1 -> IDLE the next cycle.
4. Out of range, DEPTH=256:
   - Store 0x0100 data 0x1234 -> rsp_err=1, rsp_rdata=0.
   - Subsequent load of 0x0000 returns its prior value, not 0x1234.
5. Reset mid-WAIT: store 0x0020 data 0xAAAA, assert rst one cycle after accept -> no write; after reset, load 0x0020 returns its previous value.
6. LATENCY=1 back-to-back with rsp_ready tied high: two loads issued -> accept spacing exactly 2 cycles, each rsp_valid exactly 1 cycle after its accept.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions used by the responder and the processor-side
// initiator: bus widths, latency counter width and the responder state type.
package mem_bus_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Index width for a DEPTH-word array (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_responder_mem_array_sp.sv
// Single-port synchronous RAM, DEPTH x DATA_W, registered read data.
// Ports: clk_i, en_i (access strobe), we_i, addr_i, wdata_i -> rdata_o.
module mem_array_sp #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately not reset.  rdata_q only changes on a read
    // strobe, so it holds the last read value while the response is pending.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: valid/ready request and response channels in front
// of a single-port RAM, with a programmable end-to-end access latency.
// Ports: clk, rst (async, active high); req_valid/req_ready/req_write/
// req_addr/req_wdata request channel; rsp_valid/rsp_ready/rsp_rdata/rsp_err
// response channel; busy is high whenever the responder is not IDLE.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "mem_bus_responder: LATENCY must be within 1..15");
    end

    localparam int IDX_W = idx_width(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam bit               DIRECT   = (LATENCY == 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              rdsel_q, rdsel_d;

    logic              do_access;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_oor;
    logic              ram_en;
    logic [DATA_W-1:0] ram_rdata;

    // The access is issued in the cycle before RESP so the RAM's registered
    // read lands exactly on the edge that enters RESP.  With LATENCY=1 that
    // edge is the accept edge itself, so the access is fed straight from the
    // request inputs instead of the latched copy.
    always_comb begin
        acc_write = wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        do_access = 1'b0;
        if (state_q == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            do_access = DIRECT && req_valid;
        end else if (state_q == WAIT) begin
            do_access = (cnt_q == CNT_ONE);
        end
        // Full-width compare: high address bits never alias into the array.
        acc_oor = ({1'b0, acc_addr} >= DEPTH_X);
        ram_en  = do_access && !acc_oor && !rst;
    end

    mem_array_sp #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (acc_write),
        .addr_i  (acc_addr[IDX_W-1:0]),
        .wdata_i (acc_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdsel_d = rdsel_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = DIRECT ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                    rdsel_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // rdsel_q gates the RAM output so stores and errors read back as 0.
        if (do_access) begin
            err_d   = acc_oor;
            rdsel_d = !acc_write && !acc_oor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdsel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdsel_q <= rdsel_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_err   = err_q;
    assign rsp_rdata = rdsel_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: LATENCY=2 instance (A) for the
// main traffic and a LATENCY=1 instance (B) for back-to-back timing.
module tb_mem_bus_responder;

    localparam int DEPTH = 256;
    localparam int LAT_A = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_req_write;
    logic [15:0] a_req_addr, a_req_wdata;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
    logic [15:0] a_rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [15:0] b_req_addr, b_req_wdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
    logic [15:0] b_rsp_rdata;

    mem_bus_responder #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .LATENCY(LAT_A)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_write(a_req_write), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .busy(a_busy)
    );

    mem_bus_responder #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .LATENCY(1)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .busy(b_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] ref_mem [DEPTH];

    // Edge-numbered log of B's handshakes.
    int          edge_n = 0;
    int          acc_q [$];
    int          rsp_q [$];
    logic [15:0] rd_q  [$];

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (!rst && b_req_valid && b_req_ready) acc_q.push_back(edge_n);
        if (!rst && b_rsp_valid && b_rsp_ready) begin
            rsp_q.push_back(edge_n);
            rd_q.push_back(b_rsp_rdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one access, straight from the address rules.
    task automatic ref_access(input bit w, input logic [15:0] addr,
                              input logic [15:0] wd,
                              output logic [15:0] rd, output bit err);
        int idx;
        idx = int'(addr);
        if (idx >= DEPTH) begin
            rd  = '0;
            err = 1'b1;
        end else if (w) begin
            ref_mem[idx] = wd;
            rd  = '0;
            err = 1'b0;
        end else begin
            rd  = ref_mem[idx];
            err = 1'b0;
        end
    endtask

    // One transaction on A; entered and left just after a falling edge.
    task automatic a_txn(input bit w, input logic [15:0] addr,
                         input logic [15:0] wd, input int hold);
        logic [15:0] exp_rd;
        bit          exp_err;
        int          lat;
        chk("a_req_ready_idle", a_req_ready, 1);
        ref_access(w, addr, wd, exp_rd, exp_err);
        a_req_valid = 1'b1;
        a_req_write = w;
        a_req_addr  = addr;
        a_req_wdata = wd;
        a_rsp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        a_req_write = 1'($urandom);
        a_req_addr  = 16'($urandom);
        a_req_wdata = 16'($urandom);
        lat = 1;
        while (!a_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("a_latency", lat, LAT_A);
        chk("a_rdata", a_rsp_rdata, exp_rd);
        chk("a_err", a_rsp_err, exp_err);
        for (int i = 0; i < hold; i++) begin
            a_req_valid = 1'b1;
            @(negedge clk);
            chk("a_hold_valid", a_rsp_valid, 1);
            chk("a_hold_rdata", a_rsp_rdata, exp_rd);
            chk("a_hold_ready", a_req_ready, 0);
        end
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        chk("a_post_valid", a_rsp_valid, 0);
        chk("a_post_busy", a_busy, 0);
        chk("a_post_rdata", a_rsp_rdata, 0);
    endtask

    // Single transaction on B (rsp_ready tied high).
    task automatic b_txn(input bit w, input logic [15:0] addr,
                         input logic [15:0] wd);
        int t;
        b_req_valid = 1'b1;
        b_req_write = w;
        b_req_addr  = addr;
        b_req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        t = 0;
        while (b_busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("b_idle_after_txn", b_busy, 0);
    endtask

    initial begin
        logic [15:0] d, a, v0, v1;
        bit          w;
        int          h;

        a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0;
        a_rsp_ready = 1;
        b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0;
        b_rsp_ready = 1;

        // Reset values, checked before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", a_rsp_valid, 0);
        chk("rst_rdata", a_rsp_rdata, 0);
        chk("rst_err", a_rsp_err, 0);
        chk("rst_busy", a_busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", a_req_ready, 1);
        @(negedge clk);

        // Fill the whole array so every later read has a known value.
        for (int i = 0; i < DEPTH; i++) begin
            d = 16'($urandom);
            a_txn(1'b1, 16'(i), d, 0);
        end

        // Store then load.
        a_txn(1'b1, 16'h0010, 16'hBEEF, 0);
        a_txn(1'b0, 16'h0010, 16'h0000, 0);

        // Back-pressure for 5 cycles.
        a_txn(1'b0, 16'h0010, 16'h0000, 5);

        // Out-of-range store must not alias address 0.
        a_txn(1'b1, 16'h0100, 16'h1234, 0);
        a_txn(1'b0, 16'h0000, 16'h0000, 0);
        a_txn(1'b0, 16'hFFFF, 16'h0000, 1);

        // Reset while in WAIT: store is dropped.
        a_req_valid = 1'b1;
        a_req_write = 1'b1;
        a_req_addr  = 16'h0020;
        a_req_wdata = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("wait_rst_busy", a_busy, 0);
        chk("wait_rst_valid", a_rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        a_txn(1'b0, 16'h0020, 16'h0000, 0);

        // Reset while in RESP: store has committed, response is discarded.
        a_req_valid = 1'b1;
        a_req_write = 1'b1;
        a_req_addr  = 16'h0030;
        a_req_wdata = 16'h5A5A;
        a_rsp_ready = 1'b0;
        ref_mem[16'h0030] = 16'h5A5A;
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        @(negedge clk);
        chk("resp_rst_pre_valid", a_rsp_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("resp_rst_valid", a_rsp_valid, 0);
        chk("resp_rst_err", a_rsp_err, 0);
        chk("resp_rst_busy", a_busy, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_txn(1'b0, 16'h0030, 16'h0000, 0);

        // Random traffic against the reference array.
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom);
            if ($urandom_range(0, 7) == 0)
                a = 16'($urandom_range(DEPTH, 16'hFFFF));
            else
                a = 16'($urandom_range(0, DEPTH - 1));
            d = 16'($urandom);
            h = $urandom_range(0, 2);
            a_txn(w, a, d, h);
        end

        // LATENCY=1 back-to-back loads with rsp_ready tied high.
        v0 = 16'($urandom);
        v1 = 16'($urandom);
        b_txn(1'b1, 16'h0005, v0);
        b_txn(1'b1, 16'h0006, v1);
        acc_q.delete();
        rsp_q.delete();
        rd_q.delete();
        b_req_valid = 1'b1;
        b_req_write = 1'b0;
        b_req_addr  = 16'h0005;
        @(posedge clk);
        @(negedge clk);
        b_req_addr  = 16'h0006;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_acc_count", acc_q.size(), 2);
        chk("b2b_rsp_count", rsp_q.size(), 2);
        if (acc_q.size() == 2 && rsp_q.size() == 2) begin
            chk("b2b_spacing", acc_q[1] - acc_q[0], 2);
            chk("b2b_lat0", rsp_q[0] - acc_q[0], 1);
            chk("b2b_lat1", rsp_q[1] - acc_q[1], 1);
            chk("b2b_rd0", rd_q[0], v0);
            chk("b2b_rd1", rd_q[1], v1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
